// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Byte access initiator between a CPU-side requester and one port of the
// dual-port byte RAM. It accepts one read or write request at a time over a
// valid/ready handshake, drives the RAM port for one cycle per byte, captures
// the RAM's registered read data and returns one response per byte. Reads may
// be incrementing bursts of 1..2^LEN_W bytes, with the address wrapping at the
// top of the RAM.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid/ready     request handshake
//   req_we              1 = write, 0 = read
//   req_addr            start address
//   req_wdata           write byte
//   req_len             read burst length minus 1 (ignored for writes)
//   rsp_valid/ready     response handshake
//   rsp_rdata           read byte, 0 for write acknowledges
//   rsp_last            final response of the request
//   ram_en              RAM operation enable, one cycle per byte
//   ram_r_w             0 = read, 1 = write
//   ram_addr/ram_wdata  RAM address and write data (0 while ram_en is low)
//   ram_rdata           RAM read data, registered inside the RAM
module ram_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              ram_en,
  output logic              ram_r_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              last_q;

  // NOTE: reset is sampled on the clock edge (synchronous), and every
  // register here is updated with <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      rdata_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            // A write is always a single byte, whatever req_len says.
            len_q    <= req_we ? '0 : req_len;
            beat_cnt <= '0;
          end
        end
        ACCESS: begin
          // Writes skip CAPTURE, so their acknowledge is prepared here.
          if (we_q) begin
            rdata_q <= '0;
            last_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          // The RAM's registered output holds the byte addressed in ACCESS.
          rdata_q <= ram_rdata;
          last_q  <= (beat_cnt == len_q);
        end
        RESP: begin
          // beat_cnt cannot overflow: the burst ends when it equals len_q.
          if (rsp_ready && !last_q) begin
            addr_q   <= addr_q + ADDR_W'(1);
            beat_cnt <= beat_cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_en    = 1'b0;
    ram_r_w   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        // Not ready while reset is held, even though the state is IDLE.
        req_ready = rst_n;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        ram_en    = 1'b1;
        ram_r_w   = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        state_nxt = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = last_q ? IDLE : ACCESS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_last  = last_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Self-checking bench for ram_access_ctrl. A behavioural RAM answers the
// controller's RAM port. A transaction-level model tracks the request being
// served (beat index, current address, the cycle its RAM access is due and
// the cycle its response is due) plus a golden copy of memory, and one
// negedge process compares every DUT output against it on every cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic [2:0] req_len;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_rdata;
  logic       ram_en, ram_r_w;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .ram_en    (ram_en),
    .ram_r_w   (ram_r_w),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM port: operation at the clock edge, registered read data.
  logic [7:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_r_w) ram_mem[ram_addr] <= ram_wdata;
      else         ram_rdata <= ram_mem[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit         started  = 1'b0;
  bit         m_busy   = 1'b0;
  bit         m_we     = 1'b0;
  logic [7:0] m_addr   = '0;
  logic [7:0] m_wdata  = '0;
  int         m_nbeats = 0;
  int         m_beat   = 0;
  int         cyc      = 0;
  int         m_acc_cyc = 0;
  int         m_rsp_cyc = 0;
  logic [7:0] gold [256];

  // Cycle `cyc` ends at this edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      started = 1'b1;
    end else if (m_busy) begin
      if (cyc >= m_rsp_cyc && rsp_ready) begin
        if (m_beat == m_nbeats - 1) begin
          m_busy = 1'b0;
        end else begin
          m_beat    = m_beat + 1;
          m_addr    = m_addr + 8'd1;
          m_acc_cyc = cyc + 1;   // access, capture, response: 3 cycles/byte
          m_rsp_cyc = cyc + 3;
        end
      end
    end else if (req_valid) begin
      m_busy    = 1'b1;
      m_we      = req_we;
      m_addr    = req_addr;
      m_wdata   = req_wdata;
      m_beat    = 0;
      m_nbeats  = req_we ? 1 : int'(req_len) + 1;
      m_acc_cyc = cyc + 1;
      m_rsp_cyc = cyc + (req_we ? 2 : 3);
      if (req_we) gold[req_addr] = req_wdata;
    end
    cyc = cyc + 1;
  end

  bit exp_en, exp_rv;
  always @(negedge clk) begin
    if (started) begin
      exp_en = m_busy && (cyc == m_acc_cyc);
      exp_rv = m_busy && (cyc >= m_rsp_cyc);
      check("req_ready", req_ready, rst_n && !m_busy);
      check("ram_en", ram_en, exp_en);
      check("ram_r_w", ram_r_w, exp_en ? m_we : 1'b0);
      check("ram_addr", ram_addr, exp_en ? m_addr : 8'h00);
      check("ram_wdata", ram_wdata, exp_en ? m_wdata : 8'h00);
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rsp_rdata", rsp_rdata, m_we ? 8'h00 : gold[m_addr]);
        check("rsp_last", rsp_last, m_beat == m_nbeats - 1);
      end
    end
  end

  // ---------------- activity log ----------------
  int         n_acc = 0, n_last = 0, n_en = 0;
  logic [7:0] log_addr [$];
  logic [7:0] log_wd   [$];
  logic       log_rw   [$];
  logic [7:0] log_data [$];
  logic       log_last [$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) n_acc++;
      if (ram_en) begin
        n_en++;
        log_addr.push_back(ram_addr);
        log_rw.push_back(ram_r_w);
        log_wd.push_back(ram_wdata);
      end
      if (rsp_valid && rsp_ready) begin
        log_data.push_back(rsp_rdata);
        log_last.push_back(rsp_last);
        if (rsp_last) n_last++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [2:0] len);
    bit ok = 1'b0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_len = len; req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycles from the acceptance edge to the first cycle with rsp_valid high.
  task automatic first_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  task automatic finish_req();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid && rsp_ready && rsp_last) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("done_timeout", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    check({tag, "_rsp_last"},  rsp_last,  1'b0);
    check({tag, "_ram_en"},    ram_en,    1'b0);
    check({tag, "_ram_r_w"},   ram_r_w,   1'b0);
    check({tag, "_ram_addr"},  ram_addr,  8'h00);
    check({tag, "_ram_wdata"}, ram_wdata, 8'h00);
  endtask

  // ---------------- directed scenarios ----------------
  int         lat, i0, j0, e0, a0, l0, cnt, rv;
  bit         acc;
  logic [7:0] exp_a [4];
  logic [7:0] exp_d [4];
  logic       exp_l [4];
  bit         v_we   [12];
  logic [7:0] v_addr [12];
  logic [7:0] v_wd   [12];
  logic [2:0] v_len  [12];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // Write 0x3C to 0x80: one write access, ack two cycles after acceptance.
    i0 = log_addr.size(); j0 = log_data.size();
    issue(1'b1, 8'h80, 8'h3C, 3'd0);
    first_rsp(lat);
    check("wr_latency", lat, 2);
    finish_req();
    check("wr_en_count", log_addr.size() - i0, 1);
    check("wr_rw", log_rw[i0], 1'b1);
    check("wr_addr", log_addr[i0], 8'h80);
    check("wr_wdata", log_wd[i0], 8'h3C);
    check("wr_ack_data", log_data[j0], 8'h00);
    check("wr_ack_last", log_last[j0], 1'b1);

    // Preload: 0x10 = A5, FE..01 = 11,22,33,44 (len field ignored on writes).
    issue(1'b1, 8'h10, 8'hA5, 3'd7); finish_req();
    issue(1'b1, 8'hFE, 8'h11, 3'd0); finish_req();
    issue(1'b1, 8'hFF, 8'h22, 3'd0); finish_req();
    issue(1'b1, 8'h00, 8'h33, 3'd0); finish_req();
    issue(1'b1, 8'h01, 8'h44, 3'd0); finish_req();

    // Read back 0x80.
    j0 = log_data.size();
    issue(1'b0, 8'h80, 8'h00, 3'd0); finish_req();
    check("rd80_data", log_data[j0], 8'h3C);

    // Single read of 0x10.
    i0 = log_addr.size(); j0 = log_data.size();
    issue(1'b0, 8'h10, 8'h00, 3'd0);
    first_rsp(lat);
    check("rd_latency", lat, 3);
    check("rd_data_at_valid", rsp_rdata, 8'hA5);
    check("rd_last_at_valid", rsp_last, 1'b1);
    finish_req();
    check("rd_en_count", log_addr.size() - i0, 1);
    check("rd_addr", log_addr[i0], 8'h10);
    check("rd_rw", log_rw[i0], 1'b0);
    check("rd_rsp_count", log_data.size() - j0, 1);

    // Wrapping burst from 0xFE, 4 bytes.
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    i0 = log_addr.size(); j0 = log_data.size();
    issue(1'b0, 8'hFE, 8'h00, 3'd3); finish_req();
    check("wrap_en_count", log_addr.size() - i0, 4);
    check("wrap_rsp_count", log_data.size() - j0, 4);
    for (int b = 0; b < 4; b++) begin
      check("wrap_addr", log_addr[i0 + b], exp_a[b]);
      check("wrap_data", log_data[j0 + b], exp_d[b]);
      check("wrap_last", log_last[j0 + b], exp_l[b]);
    end

    // Backpressure: len=1 burst, response stalled on beat 0.
    rsp_ready = 1'b0;
    i0 = log_addr.size(); j0 = log_data.size();
    issue(1'b0, 8'hFE, 8'h55, 3'd1);
    first_rsp(lat);
    check("bp_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid_held", rsp_valid, 1'b1);
      check("bp_data_held", rsp_rdata, 8'h11);
      check("bp_last_held", rsp_last, 1'b0);
      check("bp_no_ram", ram_en, 1'b0);
    end
    check("bp_en_during_stall", log_addr.size() - i0, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    finish_req();
    check("bp_en_count", log_addr.size() - i0, 2);
    check("bp_addr1", log_addr[i0 + 1], 8'hFF);
    check("bp_data0", log_data[j0], 8'h11);
    check("bp_data1", log_data[j0 + 1], 8'h22);
    check("bp_last1", log_last[j0 + 1], 1'b1);

    // Handshake discipline: req_valid held high, random rsp_ready.
    v_we   = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    v_addr = '{8'h20, 8'h20, 8'hFE, 8'h21, 8'h20, 8'h80, 8'h80, 8'hFF, 8'hFE, 8'h10, 8'h22, 8'h20};
    v_wd   = '{8'h5A, 8'h00, 8'h00, 8'h6B, 8'h00, 8'hC3, 8'h00, 8'h99, 8'h00, 8'h00, 8'h7E, 8'h00};
    v_len  = '{3'd0, 3'd0, 3'd3, 3'd0, 3'd1, 3'd0, 3'd0, 3'd5, 3'd1, 3'd0, 3'd7, 3'd2};
    a0 = n_acc; l0 = n_last; e0 = n_en;
    req_valid = 1'b1;
    for (int r = 0; r < 12; r++) begin
      req_we = v_we[r]; req_addr = v_addr[r]; req_wdata = v_wd[r]; req_len = v_len[r];
      acc = 1'b0;
      for (int k = 0; k < 80 && !acc; k++) begin
        @(negedge clk);
        acc = req_ready;
        @(posedge clk); #1;
        rsp_ready = 1'($urandom_range(0, 1));
      end
      check("hs_accept_timeout", acc, 1'b1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = req_ready;
    end
    check("hs_drain_timeout", acc, 1'b1);
    check("hs_accepts", n_acc - a0, 12);
    check("hs_completions", n_last - l0, 12);
    check("hs_ram_pulses", n_en - e0, 19);
    @(posedge clk); #1;

    // Reset during CAPTURE of beat 1 of a len=7 burst.
    issue(1'b0, 8'hFE, 8'h00, 3'd7);
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 2; k++) begin
      @(negedge clk);
      if (ram_en) cnt++;
    end
    check("rst_beat1_seen", cnt, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = 0;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid || ram_en) rv++;
      @(negedge clk);
    end
    check("midrst_no_activity", rv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
